instruction_fetch: RTL and testbench

Producer end of the opcode interface consumed by the instruction decoder. Holds the program counter, issues single-outstanding byte reads to instruction memory and buffers returned opcodes in a small prefetch FIFO. Presents each opcode with its PC through a valid/ready handshake. Flushes and restarts on a redirect driven by the jump/branch resolution logic.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instruction_fetch.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the fetch unit and the instruction decoder.
//   OPCODE_W         : width of one opcode byte, also used by the decoder
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_state_t    : fetch sequencer states
package cpu_pkg;

  localparam int OPCODE_W         = 8;
  localparam int DEFAULT_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- small synchronous prefetch FIFO holding {opcode, pc} entries.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears pointers/count)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (ignored while empty)
//   flush      : empty the FIFO; wins over push and pop
//   count      : number of valid entries, 0..DEPTH
//   head_data  : head entry (undefined while count is 0)
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pop_en;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign pop_en = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once count says so.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch -- program counter, single-outstanding instruction memory
// reads and a prefetch FIFO feeding the decoder over a valid/ready handshake.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   imem_req/imem_addr         : read request and address (current pc)
//   imem_ready                 : memory accepts the request this cycle
//   imem_valid/imem_data       : returned opcode byte
//   op_valid/opcode/op_pc      : FIFO head towards the decoder
//   op_ready                   : decoder consumes the head this cycle
//   redirect/redirect_addr     : taken jump/branch; flush and refetch
//   perf_fetch_cnt/perf_flush_cnt (only with IFETCH_PERF_EN defined):
//                                saturating push and redirect counters
// Build option: define IFETCH_PERF_EN to add the performance counters.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ready,
  input  logic                imem_valid,
  input  logic [OPCODE_W-1:0] imem_data,
  output logic                op_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   op_pc,
  input  logic                op_ready,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_addr
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [15:0]         perf_flush_cnt
`endif
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0]          pc_q, pc_d;
  logic [CNT_W-1:0]           count;
  logic [OPCODE_W+ADDR_W-1:0] head_data;
  logic                       issue;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic                       in_flight;

  // Issue only while a free slot remains for the response, so the FIFO
  // can never overflow even if the decoder stalls.
  assign issue     = (state_q == FETCH) && (count < DEPTH_C);
  assign accept    = issue && imem_ready;
  assign in_flight = (state_q == WAIT) || (state_q == DISCARD);

  // A redirect flushes the FIFO, so neither push nor pop may take effect.
  assign push = (state_q == WAIT) && imem_valid && !redirect;
  assign pop  = op_valid && op_ready && !redirect;

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign op_valid  = (count != '0);
  assign opcode    = op_valid ? head_data[ADDR_W +: OPCODE_W] : '0;
  assign op_pc     = op_valid ? head_data[ADDR_W-1:0]         : '0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (accept) pc_d = pc_q + 1'b1;
    case (state_q)
      IDLE:          state_d = FETCH;
      FETCH:         if (accept) state_d = WAIT;
      WAIT, DISCARD: if (imem_valid) state_d = FETCH;
      default:       state_d = IDLE;
    endcase
    if (redirect) begin
      pc_d = redirect_addr;
      // Whatever is still in flight after this edge belongs to the old
      // stream and must be dropped; a response landing this very cycle
      // is already dropped by the flush, so there is nothing to wait for.
      if (accept || (in_flight && !imem_valid)) state_d = DISCARD;
      else                                      state_d = FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // In WAIT the pc has already advanced past the requested address and
  // cannot change without leaving WAIT, so the request address is pc-1.
  fetch_fifo #(
    .WIDTH(OPCODE_W + ADDR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({imem_data, pc_q - 1'b1}),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head_data(head_data)
  );

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_flush_d = perf_flush_q;
    if (push && (perf_fetch_q != '1))     perf_fetch_d = perf_fetch_q + 1'b1;
    if (redirect && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch -- directed scenarios followed by randomized traffic,
// all checked against a transaction-level model: a queue of expected
// {opcode, pc} entries, the expected fetch pc and the outstanding request.
module tb_instruction_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_valid = 1'b0;
  logic [7:0]  imem_data = 8'h00;
  logic        op_valid;
  logic [7:0]  opcode;
  logic [15:0] op_pc;
  logic        op_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_W  (16),
    .DEPTH   (DEPTH),
    .RESET_PC(16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_valid   (imem_valid),
    .imem_data    (imem_data),
    .op_valid     (op_valid),
    .opcode       (opcode),
    .op_pc        (op_pc),
    .op_ready     (op_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] pc;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  bit          out_pend;
  bit          out_kill;
  logic [15:0] out_addr;
  logic [15:0] exp_pc;
  bit          last_acc;
  int          pushes;
  int          flushes;
  int          consumed;
  int          mem_lat;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle, entered and left at a falling edge: check the outputs of
  // this cycle, drive the inputs, then advance the model to the next edge.
  task automatic step(input bit rdy, input bit vld, input logic [7:0] dat,
                      input bit ordy, input bit rdr, input logic [15:0] raddr);
    bit exp_req;
    bit acc;
    bit resp;
    bit pop;
    exp_req = !out_pend && (q.size() < DEPTH);
    check("op_valid", 32'(op_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("opcode", 32'(opcode), 32'(q[0].data));
      check("op_pc", 32'(op_pc), 32'(q[0].pc));
    end
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", 32'(imem_addr), 32'(exp_pc));

    imem_ready    = rdy;
    imem_valid    = vld;
    imem_data     = dat;
    op_ready      = ordy;
    redirect      = rdr;
    redirect_addr = raddr;

    acc  = exp_req && rdy;
    resp = vld && out_pend;
    pop  = (q.size() != 0) && ordy && !rdr;
    last_acc = acc;
    if (rdr) begin
      q.delete();
      flushes++;
      exp_pc = raddr;
      if (resp) out_pend = 0;
      else if (out_pend) out_kill = 1;
      if (acc) begin
        out_pend = 1;
        out_kill = 1;
      end
    end else begin
      if (pop) begin
        $display("op pc=%h opcode=%h", q[0].pc, q[0].data);
        void'(q.pop_front());
        consumed++;
      end
      if (resp) begin
        if (!out_kill) begin
          q.push_back('{data: dat, pc: out_addr});
          pushes++;
        end
        out_pend = 0;
      end
      if (acc) begin
        out_pend = 1;
        out_kill = 0;
        out_addr = exp_pc;
        exp_pc   = exp_pc + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset away from a clock edge, check the reset values right away,
  // then release; the IDLE cycle gets a stray imem_valid that must be ignored.
  task automatic do_reset();
    rst        = 1'b1;
    imem_ready = 1'b0;
    op_ready   = 1'b0;
    redirect   = 1'b0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'h0000);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_op_pc", 32'(op_pc), 32'd0);
`ifdef IFETCH_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    imem_valid = 1'b1;
    imem_data  = 8'hEE;
    check("idle_no_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    imem_valid = 1'b0;
    q.delete();
    out_pend = 0;
    out_kill = 0;
    exp_pc   = 16'h0000;
    pushes   = 0;
    flushes  = 0;
    mem_lat  = 0;
  endtask

  initial begin
    consumed = 0;
    #2;
    do_reset();

    // Sequential fetch of 0x10, 0x11, 0x12 from addresses 0..2
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h00, 1, 0, 16'h0000);
      step(0, 1, 8'(8'h10 + i), 1, 0, 16'h0000);
    end
    check("seq_head_pc", 32'(op_pc), 32'h0002);
    step(0, 0, 8'h00, 1, 0, 16'h0000);

    // Fill the FIFO with the decoder stalled
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 8'h00, 0, 0, 16'h0000);
      step(0, 1, 8'(8'h20 + i), 0, 0, 16'h0000);
    end
    step(1, 0, 8'h00, 0, 0, 16'h0000);
    check("full_no_req", 32'(imem_req), 32'd0);
    step(0, 0, 8'h00, 1, 0, 16'h0000);
    check("req_after_pop", 32'(imem_req), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1, 0, 16'h0000);

    // Redirect while waiting; the late response must be dropped
    step(1, 0, 8'h00, 0, 0, 16'h0000);
    step(0, 0, 8'h00, 0, 1, 16'h0200);
    step(0, 1, 8'hAA, 0, 0, 16'h0000);
    check("redir_op_valid", 32'(op_valid), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", 32'(imem_addr), 32'h0200);

    // Redirect together with a pop and a response in the same cycle
    step(1, 0, 8'h00, 0, 0, 16'h0000);
    step(0, 1, 8'h33, 0, 0, 16'h0000);
    step(1, 0, 8'h00, 0, 0, 16'h0000);
    step(0, 1, 8'h44, 1, 1, 16'h0300);
    check("flush_op_valid", 32'(op_valid), 32'd0);
    check("flush_req", 32'(imem_req), 32'd1);
    check("flush_addr", 32'(imem_addr), 32'h0300);

    // PC wrap at 0xFFFF
    step(0, 0, 8'h00, 0, 1, 16'hFFFF);
    step(1, 0, 8'h00, 0, 0, 16'h0000);
    step(0, 1, 8'h5A, 0, 0, 16'h0000);
    check("wrap_addr", 32'(imem_addr), 32'h0000);
    check("wrap_op_pc", 32'(op_pc), 32'h0000_FFFF);
    check("wrap_opcode", 32'(opcode), 32'h5A);
    step(0, 0, 8'h00, 1, 0, 16'h0000);

    // Reset while a request is outstanding
    step(1, 0, 8'h00, 0, 0, 16'h0000);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit          v;
      bit          rdr;
      bit          ordy;
      logic [15:0] raddr;
      if (out_pend) v = (mem_lat == 0);
      else          v = ($urandom_range(0, 9) == 0);
      rdr   = ($urandom_range(0, 19) == 0);
      raddr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      if (((c / 200) % 2) == 1) ordy = ($urandom_range(0, 2) == 0);
      else                      ordy = ($urandom_range(0, 2) != 0);
      step($urandom_range(0, 3) != 0, v, 8'($urandom), ordy, rdr, raddr);
      if (last_acc) mem_lat = $urandom_range(0, 3);
      else if (out_pend && mem_lat > 0) mem_lat--;
    end
    check("liveness", 32'(consumed > 300), 32'd1);
`ifdef IFETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, 32'(pushes));
    check("perf_flush", 32'(perf_flush_cnt), 32'(flushes));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
